// File: rtl/hp_drain_ctrl_if.sv
// hp_drain_ctrl_if: battle FSM <-> HP drain controller bundle; HP_CRIT_EN adds the low-HP flags
interface hp_drain_ctrl_if #(parameter int HP_W = 8);
  logic frame_tick, battle_start, hp1_hit, hp2_hit;
  logic [HP_W-1:0] hp1, hp2;
  logic busy, poke_faint, hp1_zero, hp2_zero, hit_drop;
`ifdef HP_CRIT_EN
  logic hp1_low, hp2_low;
  modport master(output frame_tick, battle_start, hp1_hit, hp2_hit,
                 input hp1, hp2, busy, poke_faint, hp1_zero, hp2_zero, hit_drop, hp1_low, hp2_low);
  modport slave(input frame_tick, battle_start, hp1_hit, hp2_hit,
                output hp1, hp2, busy, poke_faint, hp1_zero, hp2_zero, hit_drop, hp1_low, hp2_low);
`else
  modport master(output frame_tick, battle_start, hp1_hit, hp2_hit,
                 input hp1, hp2, busy, poke_faint, hp1_zero, hp2_zero, hit_drop);
  modport slave(input frame_tick, battle_start, hp1_hit, hp2_hit,
                output hp1, hp2, busy, poke_faint, hp1_zero, hp2_zero, hit_drop);
`endif
endinterface

// File: rtl/hp_drain_ctrl.sv
// hp_drain_ctrl: queues attack damage and drains both HP bars through one shared decrementer; HP_CRIT_EN adds low-HP flags
module hp_drain_ctrl #(
  parameter int HP_W = 8,
  parameter int MAX_HP = 100,
  parameter int DMG_TO_WILD = 20,
  parameter int DMG_TO_USER = 15,
  parameter int STEP = 1
)(
  input logic Clk,
  input logic Reset,
  hp_drain_ctrl_if.slave bus
);
  localparam logic [HP_W-1:0] MAX = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0] STP = HP_W'(STEP);
  typedef enum logic [1:0] {IDLE, DRAIN2, DRAIN1, SETTLE} state_t;
  state_t state, state_nx;
  logic [HP_W-1:0] hp1, hp2, pend1, pend2, hp1_nx, hp2_nx, pend1_nx, pend2_nx, d1, d2;
  logic acc1, acc2, dec1, dec2, drop_nx, drop_q;
  function automatic logic [HP_W-1:0] sat_add(input logic [HP_W-1:0] p, input logic [HP_W-1:0] dmg);
    logic [HP_W:0] s;
    s = {1'b0, p} + {1'b0, dmg};
    return (s > {1'b0, MAX}) ? MAX : s[HP_W-1:0];
  endfunction
  function automatic logic [HP_W-1:0] min3(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b, input logic [HP_W-1:0] c);
    logic [HP_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction
  always_comb begin
    acc1 = bus.hp1_hit && (hp1 != '0 || pend1 != '0);
    acc2 = bus.hp2_hit && (hp2 != '0 || pend2 != '0);
    d1 = min3(STP, pend1, hp1);
    d2 = min3(STP, pend2, hp2);
    dec1 = state == DRAIN1 && bus.frame_tick;
    dec2 = state == DRAIN2 && bus.frame_tick;
    hp1_nx = dec1 ? hp1 - d1 : hp1;
    hp2_nx = dec2 ? hp2 - d2 : hp2;
    pend1_nx = dec1 ? pend1 - d1 : pend1;
    pend2_nx = dec2 ? pend2 - d2 : pend2;
    pend1_nx = acc1 ? sat_add(pend1_nx, HP_W'(DMG_TO_USER)) : pend1_nx;
    pend2_nx = acc2 ? sat_add(pend2_nx, HP_W'(DMG_TO_WILD)) : pend2_nx;
    // a fainted Pokemon can owe no further damage
    pend1_nx = (hp1_nx == '0) ? '0 : pend1_nx;
    pend2_nx = (hp2_nx == '0) ? '0 : pend2_nx;
    drop_nx = !bus.battle_start && ((bus.hp1_hit && !acc1) || (bus.hp2_hit && !acc2));
    hp1_nx = bus.battle_start ? MAX : hp1_nx;
    hp2_nx = bus.battle_start ? MAX : hp2_nx;
    pend1_nx = bus.battle_start ? '0 : pend1_nx;
    pend2_nx = bus.battle_start ? '0 : pend2_nx;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = bus.battle_start ? IDLE :
               state == IDLE   ? (pend2 != '0 ? DRAIN2 : pend1 != '0 ? DRAIN1 : IDLE) :
               state == DRAIN2 ? ((dec2 && pend2_nx == '0) ? SETTLE : DRAIN2) :
               state == DRAIN1 ? ((dec1 && pend1_nx == '0) ? SETTLE : DRAIN1) : IDLE;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      hp1 <= MAX;
      hp2 <= MAX;
      pend1 <= '0;
      pend2 <= '0;
      drop_q <= 1'b0;
    end else begin
      hp1 <= hp1_nx;
      hp2 <= hp2_nx;
      pend1 <= pend1_nx;
      pend2 <= pend2_nx;
      drop_q <= drop_nx;
    end
  always_comb begin
    bus.hp1 = hp1;
    bus.hp2 = hp2;
    bus.busy = pend1 != '0 || pend2 != '0 || state != IDLE;
    bus.hp1_zero = hp1 == '0;
    bus.hp2_zero = hp2 == '0;
    bus.poke_faint = hp1 == '0 || hp2 == '0;
    bus.hit_drop = drop_q;
  end
`ifdef HP_CRIT_EN
  localparam logic [HP_W-1:0] LOW = HP_W'(MAX_HP >> 2);
  logic low1, low2;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      low1 <= 1'b0;
      low2 <= 1'b0;
    end else begin
      low1 <= hp1_nx != '0 && hp1_nx <= LOW;
      low2 <= hp2_nx != '0 && hp2_nx <= LOW;
    end
  assign bus.hp1_low = low1;
  assign bus.hp2_low = low2;
`endif
endmodule

// File: tb/tb_hp_drain_ctrl.sv
// tb_hp_drain_ctrl: directed scenarios plus random pulses checked against a cycle-level damage/drain model
module tb_hp_drain_ctrl;
  logic Clk = 0, Reset = 1;
  int total = 0, bad = 0;
  hp_drain_ctrl_if #(.HP_W(8)) bus();
  hp_drain_ctrl dut(.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;

  int m_hp[1:2], m_p[1:2], m_srv;
  bit m_settle, m_drop;

  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction

  function automatic void model_reset();
    m_hp[1] = 100; m_hp[2] = 100; m_p[1] = 0; m_p[2] = 0;
    m_srv = 0; m_settle = 0; m_drop = 0;
  endfunction

  // damage queue + one server that drains one Pokemon at a time, then rests a cycle
  function automatic void model_step(input bit t, input bit bs, input bit h1, input bit h2);
    int op[1:2];
    bit hit[1:2], acc[1:2];
    int dmg[1:2];
    int d;
    hit[1] = h1; hit[2] = h2; dmg[1] = 15; dmg[2] = 20;
    if (bs) begin
      model_reset();
      return;
    end
    op = m_p;
    m_drop = 0;
    for (int s = 1; s <= 2; s++) begin
      acc[s] = hit[s] && !(m_hp[s] == 0 && m_p[s] == 0);
      if (hit[s] && !acc[s]) m_drop = 1;
    end
    if (m_srv != 0 && t) begin
      d = imin(1, imin(m_p[m_srv], m_hp[m_srv]));
      m_hp[m_srv] -= d;
      m_p[m_srv] -= d;
    end
    for (int s = 1; s <= 2; s++) begin
      if (acc[s]) m_p[s] = imin(m_p[s] + dmg[s], 100);
      if (m_hp[s] == 0) m_p[s] = 0;
    end
    if (m_settle) m_settle = 0;
    else if (m_srv != 0) begin
      if (t && m_p[m_srv] == 0) begin m_srv = 0; m_settle = 1; end
    end else m_srv = op[2] != 0 ? 2 : op[1] != 0 ? 1 : 0;
  endfunction

  function automatic bit m_busy();
    return m_p[1] != 0 || m_p[2] != 0 || m_srv != 0 || m_settle;
  endfunction

  task automatic cyc(input bit t, input bit bs, input bit h1, input bit h2);
    bus.frame_tick = t; bus.battle_start = bs; bus.hp1_hit = h1; bus.hp2_hit = h2;
    @(posedge Clk);
    model_step(t, bs, h1, h2);
    @(negedge Clk);
    bus.frame_tick = 0; bus.battle_start = 0; bus.hp1_hit = 0; bus.hp2_hit = 0;
  endtask

  task automatic test_reset();
    bus.frame_tick = 0; bus.battle_start = 0; bus.hp1_hit = 0; bus.hp2_hit = 0;
    Reset = 1;
    model_reset();
    repeat (2) @(negedge Clk);
    total++; if (bus.hp1 !== 8'd100 || bus.hp2 !== 8'd100) begin bad++; $display("FAIL reset_hp got=%0d/%0d exp=100/100", bus.hp1, bus.hp2); end
    total++; if ({bus.busy, bus.hit_drop, bus.poke_faint, bus.hp1_zero, bus.hp2_zero} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.busy, bus.hit_drop, bus.poke_faint, bus.hp1_zero, bus.hp2_zero}); end
    Reset = 0;
    @(negedge Clk);
  endtask

  task automatic test_single_hit();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_after_hit got=%b exp=1", bus.busy); end
    cyc(0, 0, 0, 0);
    total++; if (bus.hp2 !== 8'd100) begin bad++; $display("FAIL single_no_dec_on_entry got=%0d exp=100", bus.hp2); end
    for (int k = 1; k <= 25; k++) begin
      cyc(1, 0, 0, 0);
      if (k == 1) begin total++; if (bus.hp2 !== 8'd99) begin bad++; $display("FAIL single_first_tick got=%0d exp=99", bus.hp2); end end
      if (k == 20) begin
        total++; if (bus.hp2 !== 8'd80) begin bad++; $display("FAIL single_hp2 got=%0d exp=80", bus.hp2); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_settle got=%b exp=1", bus.busy); end
      end
      if (k == 21) begin total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%b exp=0", bus.busy); end end
    end
    total++; if (bus.hp2 !== 8'd80 || bus.hp1 !== 8'd100 || bus.poke_faint !== 1'b0) begin bad++; $display("FAIL single_final got=%0d/%0d/%b exp=100/80/0", bus.hp1, bus.hp2, bus.poke_faint); end
  endtask

  task automatic drain_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 400) begin cyc(1, 0, 0, 0); n++; end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_timeout got busy=%b exp=0", nm, bus.busy); end
  endtask

  task automatic test_faint_clamp();
    cyc(0, 1, 0, 0);
    repeat (6) cyc(0, 0, 1, 0);
    drain_idle("faint_prep");
    total++; if (bus.hp1 !== 8'd10) begin bad++; $display("FAIL faint_prep_hp1 got=%0d exp=10", bus.hp1); end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 0, 0, 0);
      if (k == 9) begin total++; if (bus.hp1 !== 8'd1 || bus.poke_faint !== 1'b0) begin bad++; $display("FAIL faint_tick9 got=%0d/%b exp=1/0", bus.hp1, bus.poke_faint); end end
    end
    total++; if (bus.hp1 !== 8'd0 || bus.poke_faint !== 1'b1 || bus.hp1_zero !== 1'b1 || bus.hp2_zero !== 1'b0) begin bad++; $display("FAIL faint_zero got=%0d/%b/%b/%b exp=0/1/1/0", bus.hp1, bus.poke_faint, bus.hp1_zero, bus.hp2_zero); end
    cyc(0, 0, 0, 0);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL faint_pend_clear got busy=%b exp=0", bus.busy); end
    cyc(0, 0, 1, 0);
    total++; if (bus.hit_drop !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL faint_drop got=%b/%b exp=1/0", bus.hit_drop, bus.busy); end
    cyc(0, 0, 0, 0);
    total++; if (bus.hit_drop !== 1'b0 || bus.poke_faint !== 1'b1) begin bad++; $display("FAIL faint_drop_pulse got=%b/%b exp=0/1", bus.hit_drop, bus.poke_faint); end
  endtask

  task automatic test_simultaneous();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1, 0, 0, 0);
      total++; if (bus.hp2 !== 8'(100 - k) || bus.hp1 !== 8'd100) begin bad++; $display("FAIL simul_hp2_first k=%0d got=%0d/%0d exp=100/%0d", k, bus.hp1, bus.hp2, 100 - k); end
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    total++; if (bus.hp1 !== 8'd100) begin bad++; $display("FAIL simul_gap got=%0d exp=100", bus.hp1); end
    repeat (15) cyc(1, 0, 0, 0);
    total++; if (bus.hp1 !== 8'd85 || bus.hp2 !== 8'd80) begin bad++; $display("FAIL simul_final got=%0d/%0d exp=85/80", bus.hp1, bus.hp2); end
    drain_idle("simul");
  endtask

  task automatic test_accumulate();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    for (int k = 6; k <= 40; k++) begin
      cyc(1, 0, 0, 0);
      total++; if (bus.hp2 !== 8'(100 - k)) begin bad++; $display("FAIL accum_hp2 k=%0d got=%0d exp=%0d", k, bus.hp2, 100 - k); end
    end
    drain_idle("accum");
    total++; if (bus.hp2 !== 8'd60) begin bad++; $display("FAIL accum_hold got=%0d exp=60", bus.hp2); end
    repeat (6) cyc(0, 0, 0, 1);
    drain_idle("accum_sat");
    total++; if (bus.hp2 !== 8'd0 || bus.hp2_zero !== 1'b1 || bus.poke_faint !== 1'b1 || bus.hp1 !== 8'd100) begin bad++; $display("FAIL accum_sat got=%0d/%b/%b/%0d exp=0/1/1/100", bus.hp2, bus.hp2_zero, bus.poke_faint, bus.hp1); end
  endtask

  task automatic test_abort();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    total++; if (bus.hp2 !== 8'd95) begin bad++; $display("FAIL abort_pre got=%0d exp=95", bus.hp2); end
    cyc(1, 1, 0, 1);
    total++; if (bus.hp1 !== 8'd100 || bus.hp2 !== 8'd100 || bus.busy !== 1'b0 || bus.hit_drop !== 1'b0) begin bad++; $display("FAIL abort_state got=%0d/%0d/%b/%b exp=100/100/0/0", bus.hp1, bus.hp2, bus.busy, bus.hit_drop); end
    repeat (3) cyc(1, 0, 0, 0);
    total++; if (bus.hp2 !== 8'd100 || bus.busy !== 1'b0) begin bad++; $display("FAIL abort_hold got=%0d/%b exp=100/0", bus.hp2, bus.busy); end
  endtask

  task automatic test_reset_mid_drain();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    total++; if (bus.hp2 !== 8'd97) begin bad++; $display("FAIL rstmid_pre got=%0d exp=97", bus.hp2); end
    #2 Reset = 1;
    #1;
    total++; if (bus.hp2 !== 8'd100 || bus.hp1 !== 8'd100 || bus.busy !== 1'b0 || bus.poke_faint !== 1'b0) begin bad++; $display("FAIL rstmid_async got=%0d/%0d/%b/%b exp=100/100/0/0", bus.hp1, bus.hp2, bus.busy, bus.poke_faint); end
    model_reset();
    @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
    repeat (3) cyc(1, 0, 0, 0);
    total++; if (bus.hp1 !== 8'd100 || bus.hp2 !== 8'd100 || bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_nostate got=%0d/%0d/%b exp=100/100/0", bus.hp1, bus.hp2, bus.busy); end
  endtask

  task automatic test_random();
    bit t, bs, h1, h2;
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      t = $urandom_range(0, 1) == 0;
      bs = $urandom_range(0, 299) == 0;
      h1 = $urandom_range(0, 24) == 0;
      h2 = $urandom_range(0, 24) == 0;
      cyc(t, bs, h1, h2);
      total++; if (bus.hp1 !== 8'(m_hp[1]) || bus.hp2 !== 8'(m_hp[2])) begin bad++; $display("FAIL rand_hp i=%0d got=%0d/%0d exp=%0d/%0d", i, bus.hp1, bus.hp2, m_hp[1], m_hp[2]); end
      total++; if (bus.busy !== m_busy() || bus.hit_drop !== m_drop) begin bad++; $display("FAIL rand_busy_drop i=%0d got=%b/%b exp=%b/%b", i, bus.busy, bus.hit_drop, m_busy(), m_drop); end
      total++; if (bus.poke_faint !== (m_hp[1] == 0 || m_hp[2] == 0) || bus.hp1_zero !== (m_hp[1] == 0) || bus.hp2_zero !== (m_hp[2] == 0)) begin bad++; $display("FAIL rand_zero i=%0d got=%b%b%b", i, bus.poke_faint, bus.hp1_zero, bus.hp2_zero); end
    end
  endtask

`ifdef HP_CRIT_EN
  task automatic test_crit();
    int n = 0;
    bit seen = 0;
    cyc(0, 1, 0, 0);
    total++; if (bus.hp1_low !== 1'b0 || bus.hp2_low !== 1'b0) begin bad++; $display("FAIL crit_start got=%b/%b exp=0/0", bus.hp1_low, bus.hp2_low); end
    repeat (6) cyc(0, 0, 0, 1);
    while (bus.busy && n < 400) begin
      cyc(1, 0, 0, 0);
      n++;
      if (m_hp[2] == 25) seen = 1;
      total++; if (bus.hp2_low !== (m_hp[2] != 0 && m_hp[2] <= 25) || bus.hp1_low !== 1'b0) begin bad++; $display("FAIL crit_low hp2=%0d got=%b exp=%b", bus.hp2, bus.hp2_low, m_hp[2] != 0 && m_hp[2] <= 25); end
    end
    total++; if (!seen || bus.hp2 !== 8'd0 || bus.hp2_low !== 1'b0) begin bad++; $display("FAIL crit_end got hp2=%0d low=%b seen25=%b exp=0/0/1", bus.hp2, bus.hp2_low, seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_faint_clamp();
    test_simultaneous();
    test_accumulate();
    test_abort();
    test_reset_mid_drain();
    test_random();
`ifdef HP_CRIT_EN
    test_crit();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
